fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read data and output data.
REQ-002 Parameter BURST_LEN, default 3, words per burst; elaboration SHALL fail unless 1 <= BURST_LEN <= ALMOST_EMPTY_LEVEL+1.
REQ-003 Parameter ALMOST_EMPTY_LEVEL, default 2, SHALL equal the attached FIFO's almost-empty level.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, idle cycles with a partially filled FIFO before a drain starts; SHALL be >= 1.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 empty_i  input  1  FIFO empty flag.
REQ-008 almost_empty_i  input  1  FIFO almost-empty flag.
REQ-009 rden_o  output  1  FIFO read enable.
REQ-010 rdata_i  input  DATA_WIDTH  FIFO head data, valid in the same cycle as rden_o.
REQ-011 flush_i  input  1  request to drain all FIFO contents regardless of level.
REQ-012 valid_o  output  1  output word valid.
REQ-013 ready_i  input  1  downstream accepts word when valid_o & ready_i.
REQ-014 data_o  output  DATA_WIDTH  output word.
REQ-015 last_o  output  1  word ends a burst or is a drain single.
REQ-016 busy_o  output  1  high when state is not IDLE.

Function
REQ-017 States SHALL be IDLE, BURST, DRAIN.
REQ-018 IDLE -> BURST when !empty_i & !almost_empty_i; else IDLE -> DRAIN when !empty_i & (flush_i | timeout hit); BURST has priority.
REQ-019 rden_o SHALL be 1 only in BURST or DRAIN, with !empty_i and output buffer occupancy < 2; it SHALL never be 1 while empty_i = 1.
REQ-020 Each rden_o cycle SHALL push {rdata_i, last} into a 2-entry in-order output buffer in that cycle.
REQ-021 BURST: beat counter counts reads 0..BURST_LEN-1; the read at count BURST_LEN-1 SHALL carry last=1, clear the counter and return to IDLE; earlier reads carry last=0.
REQ-022 DRAIN: every read SHALL carry last=1; return to IDLE in the first cycle with empty_i=1 and no read.
REQ-023 valid_o = occupancy != 0; data_o/last_o SHALL show the oldest entry; occupancy updates +push -pop, simultaneous push and pop keeps occupancy.
REQ-024 Sustained throughput SHALL be one word per cycle when ready_i is held high.
REQ-025 flush_i is level-sensitive; if it is asserted during BURST, the burst completes first.
REQ-026 Latency: first rden_o one cycle after the IDLE exit condition; valid_o the cycle after that read.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, beat and timeout counters 0, occupancy 0, valid_o 0, last_o 0, data_o 0, busy_o 0, rden_o 0.
REQ-028 Reset mid-burst SHALL discard buffered words; no burst resumption.

Configuration
REQ-029 Macro FIFO_RD_TIMEOUT_EN defined: timeout counter counts IDLE cycles with !empty_i & almost_empty_i, clears otherwise; hit at TIMEOUT_CYCLES-1 consecutive counted cycles.
REQ-030 FIFO_RD_TIMEOUT_EN undefined: no timeout counter; a DRAIN starts only on flush_i.

Structure
REQ-031 Package fifo_rd_pkg SHALL hold the state enum and the buffer entry struct {data, last}; DATA_WIDTH stays a module parameter.
REQ-032 The 2-entry buffer SHALL be sub-module rd_skid_buf (push, entry in, pop, valid, entry out, occupancy).

Verification
REQ-033 FIFO loaded with 3 words A,B,C (level 2), ready_i=1 -> rden_o three consecutive cycles, outputs A,B,C with last_o only on C, back to IDLE.
REQ-034 7 words, ready_i=1 -> two bursts A..C and D..F with last on C and F, then G; G leaves only via DRAIN from flush_i or, with FIFO_RD_TIMEOUT_EN, after 15 further idle cycles, last_o=1.
REQ-035 3 words, ready_i=0 -> exactly 2 reads, rden_o held low, valid_o=1 holding A; raising ready_i yields A,B,C in order, no loss or duplicate.
REQ-036 1 word, flush_i=1 -> DRAIN, one read with last_o=1, rden_o never high with empty_i=1, IDLE after empty.
REQ-037 rst_n asserted mid-burst with 1 buffered word -> valid_o, busy_o, rden_o 0 asynchronously; after release IDLE, next burst starts at beat 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO burst reader: controller states and the output buffer entry.
package fifo_rd_pkg;

    // Widest data path the buffer entry can carry; each instance uses its low DATA_WIDTH bits.
    localparam int RD_MAX_DW = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [RD_MAX_DW-1:0] data;
        logic                 last;
    } rd_entry_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order output buffer; entry 0 is always the head shown downstream.
module rd_skid_buf
    import fifo_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  rd_entry_t  i_ent,
    input  logic       i_pop,
    output logic       o_valid,
    output rd_entry_t  o_ent,
    output logic [1:0] o_occ
);

    rd_entry_t  r_ent0;
    rd_entry_t  r_ent1;
    logic [1:0] r_occ;
    logic       w_pop;

    assign w_pop = i_pop && (r_occ != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_ent0 <= i_ent;
                        r_occ  <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_ent1 <= i_ent;
                        r_occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word queues behind whatever remains.
                    if (r_occ == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_ent;
                    end else begin
                        r_ent0 <= i_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_ent   = r_ent0;
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a FIFO in fixed bursts, or drains it word by word on flush/timeout.
// Define FIFO_RD_TIMEOUT_EN to drain a partially filled FIFO after TIMEOUT_CYCLES idle cycles.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int BURST_LEN          = 3,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  empty_i,
    input  logic                  almost_empty_i,
    output logic                  rden_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    generate
        if (BURST_LEN < 1 || BURST_LEN > ALMOST_EMPTY_LEVEL + 1) begin : g_bad_burst
            $error("BURST_LEN must lie in 1..ALMOST_EMPTY_LEVEL+1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be >= 1");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > RD_MAX_DW) begin : g_bad_width
            $error("DATA_WIDTH out of range for rd_entry_t");
        end
    endgenerate

    rd_state_e     r_state;
    rd_state_e     w_state_nxt;
    logic [BW-1:0] r_beat;
    logic          w_rden;
    logic          w_last;
    logic          w_to_hit;
    logic          w_valid;
    logic          w_pop;
    logic [1:0]    w_occ;
    rd_entry_t     w_push_ent;
    rd_entry_t     w_out_ent;
    logic          w_unused_hi;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          w_to_count;

    // Only a FIFO that cannot start a burst but still holds data ages toward a drain.
    assign w_to_count = (r_state == ST_IDLE) && !empty_i && almost_empty_i;
    assign w_to_hit   = w_to_count && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_count) begin
            r_to_cnt <= '0;
        end else if (!w_to_hit) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!empty_i && !almost_empty_i) begin
                    w_state_nxt = ST_BURST;
                end else if (!empty_i && (flush_i || w_to_hit)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_BURST: begin
                if (w_rden && (r_beat == LAST_BEAT)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (empty_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rden = 1'b0;
        w_last = 1'b0;
        case (r_state)
            ST_BURST: begin
                w_rden = !empty_i && (w_occ < 2'd2);
                w_last = (r_beat == LAST_BEAT);
            end
            ST_DRAIN: begin
                w_rden = !empty_i && (w_occ < 2'd2);
                w_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if ((r_state == ST_BURST) && w_rden) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
        end
    end

    always_comb begin
        w_push_ent      = '0;
        w_push_ent.data = RD_MAX_DW'(rdata_i);
        w_push_ent.last = w_last;
    end

    assign w_pop = w_valid && ready_i;

    rd_skid_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rden),
        .i_ent   (w_push_ent),
        .i_pop   (w_pop),
        .o_valid (w_valid),
        .o_ent   (w_out_ent),
        .o_occ   (w_occ)
    );

    assign w_unused_hi = ^(w_out_ent.data >> DATA_WIDTH);

    assign rden_o  = w_rden;
    assign valid_o = w_valid;
    assign data_o  = w_out_ent.data[DATA_WIDTH-1:0];
    assign last_o  = w_out_ent.last;
    assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, output scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty_i = 1'b1;
    logic          almost_empty_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] rdata_i = '0;
    logic          rden_o, valid_o, last_o, busy_o;
    logic [DW-1:0] data_o;

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        int          n;
        bit          flush;
        int          rdy;
        int          exp_out;
        logic [31:0] lmask;
    } vec_t;

    word_t fq[$];
    word_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    rd_cnt = 0;
    int    out_cnt = 0;
    bit    pend_pop = 1'b0;
    int    rdy_mode = 1;

    fifo_burst_reader #(
        .DATA_WIDTH(DW), .BURST_LEN(3), .ALMOST_EMPTY_LEVEL(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .empty_i        (empty_i),
        .almost_empty_i (almost_empty_i),
        .rden_o         (rden_o),
        .rdata_i        (rdata_i),
        .flush_i        (flush_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .data_o         (data_o),
        .last_o         (last_o),
        .busy_o         (busy_o)
    );

    // FIFO model and ready driver: update just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (pend_pop && fq.size() != 0) void'(fq.pop_front());
        pend_pop       = 1'b0;
        empty_i        = (fq.size() == 0);
        almost_empty_i = (fq.size() <= 2);
        rdata_i        = (fq.size() != 0) ? fq[0].data : '0;
        if (rdy_mode == 2) ready_i = ($urandom_range(0, 1) == 1);
        else               ready_i = (rdy_mode == 1);
    end

    // Monitor: sample mid-cycle, compare handshakes against the scoreboard, record reads.
    always @(negedge clk) begin
        word_t e;
        if (rst_n) begin
            checks++;
            if (rden_o && empty_i) begin
                errors++;
                $display("FAIL rden_while_empty actual=1 required=0 t=%0t", $time);
            end
            if (valid_o && ready_i) begin
                out_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", data_o);
                end else begin
                    e = sb.pop_front();
                    if (data_o !== e.data || last_o !== e.last) begin
                        errors++;
                        $display("FAIL out_word actual=%h/%b required=%h/%b", data_o, last_o, e.data, e.last);
                    end
                end
            end
            if (rden_o && fq.size() != 0) begin
                rd_cnt++;
                sb.push_back(fq[0]);
                pend_pop = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int n, input int tag, input logic [31:0] lm);
        for (int i = 0; i < n; i++) begin
            fq.push_back('{data: DW'((tag << 8) | i), last: lm[i]});
        end
    endtask

    task automatic wait_quiet(input int maxc, input string nm);
        int q = 0;
        int c = 0;
        while (q < 10 && c < maxc) begin
            @(negedge clk);
            c++;
            if (!busy_o && !valid_o && !rden_o) q++;
            else q = 0;
        end
        checks++;
        if (q < 10) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=quiet", nm, c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   rd0;
        int   c;
        vt[0] = '{3, 1'b0, 1, 3, 32'b100};
        vt[1] = '{6, 1'b0, 1, 6, 32'b100100};
        vt[2] = '{7, 1'b1, 1, 7, 32'b1100100};
        vt[3] = '{1, 1'b1, 1, 1, 32'b1};
        vt[4] = '{2, 1'b1, 2, 2, 32'b11};
        vt[5] = '{4, 1'b0, 2, 3, 32'b1100};
        vt[6] = '{7, 1'b0, 2, 6, 32'b1100100};

        // Reset state
        #12;
        chk("rst_valid", valid_o, 0);
        chk("rst_last",  last_o,  0);
        chk("rst_data",  data_o,  0);
        chk("rst_busy",  busy_o,  0);
        chk("rst_rden",  rden_o,  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three-word burst: exact latency and ordering
        load(3, 8'hA0, 32'b100);
        @(negedge clk); chk("lat_c0_rden", rden_o, 0); chk("lat_c0_busy", busy_o, 0);
        @(negedge clk); chk("lat_c1_rden", rden_o, 1); chk("lat_c1_busy", busy_o, 1); chk("lat_c1_valid", valid_o, 0);
        @(negedge clk); chk("lat_c2_rden", rden_o, 1); chk("lat_c2_data", data_o, 32'hA000); chk("lat_c2_last", last_o, 0);
        @(negedge clk); chk("lat_c3_rden", rden_o, 1); chk("lat_c3_data", data_o, 32'hA001);
        @(negedge clk); chk("lat_c4_rden", rden_o, 0); chk("lat_c4_data", data_o, 32'hA002);
        chk("lat_c4_last", last_o, 1); chk("lat_c4_busy", busy_o, 0);
        wait_quiet(100, "lat");

        // Backpressure: only two reads fit, head word held
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rd0 = rd_cnt;
        load(3, 8'hB0, 32'b100);
        repeat (8) @(negedge clk);
        chk("bp_reads", rd_cnt - rd0, 2);
        chk("bp_rden",  rden_o, 0);
        chk("bp_valid", valid_o, 1);
        chk("bp_data",  data_o, 32'hB000);
        chk("bp_busy",  busy_o, 1);
        out_cnt = 0;
        rdy_mode = 1;
        wait_quiet(100, "bp");
        chk("bp_outputs", out_cnt, 3);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset mid-burst with one buffered word
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        load(3, 8'hC0, 32'b100);
        repeat (3) @(negedge clk);
        chk("mid_pre_valid", valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_busy",  busy_o,  0);
        chk("mid_rst_rden",  rden_o,  0);
        chk("mid_rst_data",  data_o,  0);
        chk("mid_rst_last",  last_o,  0);
        sb.delete();
        fq.delete();
        pend_pop = 1'b0;
        load(3, 8'hD0, 32'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        out_cnt = 0;
        wait_quiet(100, "post_rst");
        chk("post_rst_outputs", out_cnt, 3);
        chk("post_rst_sb_empty", sb.size(), 0);

        // Vector table: load, settle, count outputs, then flush any leftover
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            out_cnt  = 0;
            rdy_mode = vt[v].rdy;
            flush_i  = vt[v].flush;
            load(vt[v].n, v + 1, vt[v].lmask);
            wait_quiet(400, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_outputs", v), out_cnt, vt[v].exp_out);
            flush_i  = 1'b1;
            rdy_mode = 1;
            wait_quiet(400, $sformatf("vec%0d_cleanup", v));
            flush_i  = 1'b0;
            chk($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
            chk($sformatf("vec%0d_fifo_empty", v), fq.size(), 0);
        end

`ifdef FIFO_RD_TIMEOUT_EN
        // Single word drains on its own after the idle timeout
        @(negedge clk);
        out_cnt = 0;
        load(1, 8'hE0, 32'b1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rden_o && c < 40);
        chk("timeout_first_read", c, TO + 1);
        wait_quiet(100, "timeout");
        chk("timeout_outputs", out_cnt, 1);
`else
        c = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
